// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable watermarks, error pulses
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags #(
   parameter int width     = 8,
   parameter int depth     = 8,
   parameter int n         = $clog2(depth),
   parameter int afull_th  = depth - 2,
   parameter int aempty_th = 1,
   parameter bit fwft      = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic [width-1:0] wdata,
   input  logic             rinc,
   output logic [width-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             walmost_full,
   output logic             ralmost_empty,
   output logic [n:0]       count,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [n-1:0] ptr_last = n'(depth - 1);
   localparam logic [n:0]   cnt_full = (n+1)'(depth);
   localparam logic [n:0]   cnt_af   = (n+1)'(afull_th);
   localparam logic [n:0]   cnt_ae   = (n+1)'(aempty_th);

   logic [width-1:0] mem [depth];
   logic [n-1:0]     wptr;
   logic [n-1:0]     rptr;
   logic             wr_ok;
   logic             rd_ok;

   // Flags come straight from the count register, so they never see winc/rinc.
   assign wfull         = (count == cnt_full);
   assign rempty        = (count == '0);
   assign walmost_full  = (count >= cnt_af);
   assign ralmost_empty = (count <= cnt_ae);

   assign wr_ok = winc & ~wfull;
   assign rd_ok = rinc & ~rempty;

   // NOTE: the storage array has no reset; only pointers and count define
   // which entries are live, so clearing it would cost logic for nothing.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= wdata;
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= winc & wfull;
         underflow <= rinc & rempty;
         // Explicit wrap compare keeps non-power-of-two depths correct.
         if (wr_ok) wptr <= (wptr == ptr_last) ? '0 : wptr + 1'b1;
         if (rd_ok) rptr <= (rptr == ptr_last) ? '0 : rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   if (fwft) begin : g_fwft
      // Head word is presented as soon as it is written; rinc pops it.
      assign rdata = mem[rptr];
   end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)     rdata <= '0;
         else if (rd_ok) rdata <= mem[rptr];
      end
   end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised scoreboard bench: three FIFO configurations share one stimulus
// stream and are compared against a queue-based model every cycle.
module tb_sync_fifo_flags;

   localparam int NI = 3;
   localparam int M_DEPTH [NI] = '{8, 6, 8};
   localparam int M_AF    [NI] = '{6, 5, 8};
   localparam int M_AE    [NI] = '{1, 0, 7};
   localparam int M_FWFT  [NI] = '{0, 0, 1};

   typedef struct packed {
      logic [3:0] count;
      logic       full;
      logic       empty;
      logic       afull;
      logic       aempty;
      logic       ovf;
      logic       unf;
      logic       rd_valid;
      logic [7:0] rdata;
   } snap_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       winc;
   logic       rinc;
   logic [7:0] wdata;

   logic [7:0] d_rdata  [NI];
   logic [3:0] d_count  [NI];
   logic       d_wfull  [NI];
   logic       d_rempty [NI];
   logic       d_af     [NI];
   logic       d_ae     [NI];
   logic       d_ovf    [NI];
   logic       d_unf    [NI];

   logic [7:0] mq      [NI][$];
   logic [7:0] last_rd [NI];
   snap_t      exp_q   [NI][$];

   int   total = 0;
   int   bad   = 0;
   event async_chk;

   always #5 clk = ~clk;

   sync_fifo_flags #(.width(8), .depth(8), .afull_th(6), .aempty_th(1), .fwft(1'b0)) u_d8 (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
      .rdata(d_rdata[0]), .wfull(d_wfull[0]), .rempty(d_rempty[0]),
      .walmost_full(d_af[0]), .ralmost_empty(d_ae[0]), .count(d_count[0]),
      .overflow(d_ovf[0]), .underflow(d_unf[0]));

   sync_fifo_flags #(.width(8), .depth(6), .afull_th(5), .aempty_th(0), .fwft(1'b0)) u_d6 (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
      .rdata(d_rdata[1]), .wfull(d_wfull[1]), .rempty(d_rempty[1]),
      .walmost_full(d_af[1]), .ralmost_empty(d_ae[1]), .count(d_count[1]),
      .overflow(d_ovf[1]), .underflow(d_unf[1]));

   sync_fifo_flags #(.width(8), .depth(8), .afull_th(8), .aempty_th(7), .fwft(1'b1)) u_fw (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
      .rdata(d_rdata[2]), .wfull(d_wfull[2]), .rempty(d_rempty[2]),
      .walmost_full(d_af[2]), .ralmost_empty(d_ae[2]), .count(d_count[2]),
      .overflow(d_ovf[2]), .underflow(d_unf[2]));

   task automatic check(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", name, i, act, exp, $time);
      end
   endtask

   // Expected visible state derived from the model queue contents alone.
   function automatic snap_t snap_now(input int i, input logic ovf, input logic unf);
      snap_t s;
      int    sz = mq[i].size();
      s.count    = 4'(sz);
      s.full     = (sz == M_DEPTH[i]);
      s.empty    = (sz == 0);
      s.afull    = (sz >= M_AF[i]);
      s.aempty   = (sz <= M_AE[i]);
      s.ovf      = ovf;
      s.unf      = unf;
      s.rd_valid = (M_FWFT[i] == 0) || (sz != 0);
      s.rdata    = (M_FWFT[i] == 0) ? last_rd[i] : ((sz != 0) ? mq[i][0] : 8'h00);
      return s;
   endfunction

   task automatic model_step(input int i, input logic w, input logic r, input logic [7:0] d);
      int         sz    = mq[i].size();
      logic       full  = (sz == M_DEPTH[i]);
      logic       empty = (sz == 0);
      logic [7:0] v;
      if (r && !empty) begin
         v = mq[i].pop_front();
         if (M_FWFT[i] == 0) last_rd[i] = v;
      end
      if (w && !full) mq[i].push_back(d);
      exp_q[i].push_back(snap_now(i, w && full, r && empty));
   endtask

   task automatic push_reset_snaps();
      for (int i = 0; i < NI; i++) begin
         mq[i].delete();
         last_rd[i] = 8'h00;
         exp_q[i].push_back(snap_now(i, 1'b0, 1'b0));
      end
   endtask

   task automatic cycle(input logic w, input logic r, input logic [7:0] d);
      @(negedge clk);
      rst_n = 1'b1;
      winc  = w;
      rinc  = r;
      wdata = d;
      for (int i = 0; i < NI; i++) model_step(i, w, r, d);
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst_n = 1'b0;
      winc  = 1'b0;
      rinc  = 1'b0;
      push_reset_snaps();
   endtask

   // Reset dropped between edges: one expectation for the immediate effect,
   // one for the following rising edge while rst_n is still low.
   task automatic mid_reset();
      @(negedge clk);
      winc = 1'b0;
      rinc = 1'b0;
      #2;
      rst_n = 1'b0;
      push_reset_snaps();
      -> async_chk;
      push_reset_snaps();
   endtask

   initial begin : monitor
      snap_t s;
      forever begin
         @(posedge clk or async_chk);
         #1;
         for (int i = 0; i < NI; i++) begin
            if (exp_q[i].size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard inst%0d: got no expectation at %0t", i, $time);
            end else begin
               s = exp_q[i].pop_front();
               check("count",         i, 16'(d_count[i]),  16'(s.count));
               check("wfull",         i, 16'(d_wfull[i]),  16'(s.full));
               check("rempty",        i, 16'(d_rempty[i]), 16'(s.empty));
               check("walmost_full",  i, 16'(d_af[i]),     16'(s.afull));
               check("ralmost_empty", i, 16'(d_ae[i]),     16'(s.aempty));
               check("overflow",      i, 16'(d_ovf[i]),    16'(s.ovf));
               check("underflow",     i, 16'(d_unf[i]),    16'(s.unf));
               if (s.rd_valid) check("rdata", i, 16'(d_rdata[i]), 16'(s.rdata));
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

   initial begin : driver
      rst_n = 1'b0;
      winc  = 1'b0;
      rinc  = 1'b0;
      wdata = 8'h00;
      push_reset_snaps();
      hold_reset();
      hold_reset();

      // Fill past full, then drain past empty.
      for (int k = 1; k <= 9; k++) cycle(1'b1, 1'b0, 8'(k));
      for (int k = 0; k < 9; k++)  cycle(1'b0, 1'b1, 8'h00);

      // Two-in/two-out bursts walk the pointers around several times.
      for (int k = 0; k < 20; k++) begin
         cycle(1'b1, 1'b0, 8'($urandom));
         cycle(1'b1, 1'b0, 8'($urandom));
         cycle(1'b0, 1'b1, 8'h00);
         cycle(1'b0, 1'b1, 8'h00);
      end

      // Simultaneous requests at mid-occupancy, when full and when empty.
      for (int k = 0; k < 4; k++)  cycle(1'b1, 1'b0, 8'($urandom));
      for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, 8'($urandom));
      for (int k = 0; k < 4; k++)  cycle(1'b1, 1'b0, 8'($urandom));
      cycle(1'b1, 1'b1, 8'h5a);
      for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b1, 1'b1, 8'h3c);
      cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b0, 1'b1, 8'h00);

      // Fall-through visibility, then reset in the middle of a burst.
      cycle(1'b1, 1'b0, 8'ha5);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h11);
      cycle(1'b1, 1'b0, 8'h22);
      cycle(1'b1, 1'b0, 8'h33);
      mid_reset();
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'(8'hc0 + k));
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 8'h00);

      // Random traffic with phases biased toward filling, draining and balance.
      for (int c = 0; c < 600; c++) begin
         int pw;
         case ((c / 60) % 3)
            0:       pw = 85;
            1:       pw = 15;
            default: pw = 50;
         endcase
         if (c == 300) mid_reset();
         cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), 8'($urandom));
      end

      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
         total++;
         if (exp_q[i].size() != 0) begin
            bad++;
            $display("FAIL drain inst%0d: got %0d pending expected 0", i, exp_q[i].size());
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. Depth need not be a power of two. It is the same-clock successor to the dual-clock FIFO top. Use it wherever producer and consumer share one clock and need watermark-based flow control, for example datapath skid buffering and burst staging ahead of the dual-clock FIFO.

## Interface
- width, 8, data word width in bits (≥1)
- depth, 8, number of storage entries (≥2, any integer)
- n, $clog2(depth), pointer width; count is n+1 bits
- afull_th, depth-2, almost-full threshold (1..depth)
- aempty_th, 1, almost-empty threshold (0..depth-1)
- fwft, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- winc  input  1  write request
- wdata  input  width  write data
- rinc  input  1  read request
- rdata  output  width  read data
- wfull  output  1  FIFO holds depth words
- rempty  output  1  FIFO holds 0 words
- walmost_full  output  1  count ≥ afull_th
- ralmost_empty  output  1  count ≤ aempty_th
- count  output  n+1  current occupancy, 0..depth
- overflow  output  1  one-cycle pulse for a rejected write
- underflow  output  1  one-cycle pulse for a rejected read

## Operation
- Storage: depth × width array, not reset. Pointers wptr and rptr range 0..depth-1 and return to 0 after depth-1 (explicit compare, no power-of-two masking). count is a separate register.
- Write accept: wr_ok = winc & ~wfull. Writes mem[wptr] ← wdata and advances wptr.
- Read accept: rd_ok = rinc & ~rempty. Advances rptr.
- count update:
  - +1 on wr_ok & ~rd_ok
  - −1 on rd_ok & ~wr_ok
  - unchanged otherwise
- Simultaneous winc and rinc:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected; overflow pulses.
  - Empty: write accepted, read rejected; underflow pulses. No write-through bypass.
- Flags are decoded combinationally from the count register, so they change on the same edge as count:
  - wfull = (count == depth)
  - rempty = (count == 0)
  - walmost_full = (count ≥ afull_th)
  - ralmost_empty = (count ≤ aempty_th)
- overflow ← winc & wfull; underflow ← rinc & rempty. Both are registered, high for exactly one cycle, and do not change any state.
- fwft = 0: rdata is a register loaded with mem[rptr] on rd_ok and held otherwise.
- fwft = 1: rdata = mem[rptr], a combinational read of the head word. It is valid whenever rempty = 0 and undefined (don't-care) when empty. rinc pops the word already presented.
- Reset (rst_n low, asynchronous) forces:
  - wptr = 0, rptr = 0, count = 0
  - rdata register = 0
  - overflow = 0, underflow = 0
  - hence rempty = 1, ralmost_empty = 1, wfull = 0, walmost_full = 0
- Reset asserted mid-operation discards all contents immediately; memory contents are not cleared. Release is synchronised externally. The first edge after release may accept a write.

## Timing
- Write to visibility: a word written at edge k clears rempty after edge k, so it is readable from cycle k+1.
  - fwft = 0: data appears on rdata after the edge that accepts rinc (1-cycle read latency).
  - fwft = 1: data is on rdata in cycle k+1 with no rinc required.
- Full to non-full: a read accepted at edge k drops wfull after edge k, so a write is accepted at edge k+1.
- Throughput: one write and one read per cycle sustained, provided 0 < count < depth.
- overflow/underflow assert the cycle after the offending request.
- No combinational path from winc or rinc to any output. In fwft = 1, rdata depends combinationally only on rptr and memory.

## Test plan
- Reset and fill (width=8, depth=8, fwft=0): hold rst_n low; check rempty=1, count=0, rdata=0x00. Write 0x01..0x08; wfull=1 after the 8th edge, count=8. A 9th winc gives overflow=1 for one cycle and count stays 8.
- Drain order (fwft=0): from full, read 8 times; rdata = 0x01..0x08 on the cycle after each accepted rinc. Then rempty=1. An extra rinc gives underflow=1 and rdata holds 0x08.
- Non-power-of-two wrap (depth=6): loop 20 times writing 2 words and reading 2. Check the output sequence is intact through pointer wrap 5→0, and count never exceeds 2.
- Watermarks (depth=8, afull_th=6, aempty_th=1): walmost_full rises on the edge where count becomes 6. ralmost_empty falls when count becomes 2 and rises again when count returns to 1.
- Simultaneous read/write: with count=4, hold winc=rinc=1 for 10 cycles; count stays 4 and data order is preserved. With the FIFO full, winc=rinc=1 gives a read, overflow=1, count=7. With it empty, winc=rinc=1 gives underflow=1, count=1.
- FWFT and reset mid-burst (fwft=1): write 0xA5; rdata=0xA5 in the next cycle with no rinc. Write 3 more words, then pulse rst_n low mid-cycle; immediately rempty=1 and count=0, and after release the FIFO refills correctly.
